// File: rtl/rx_frame_fifo_pkg.sv
// Shared definitions for the store-and-forward rx frame FIFO: write-FSM
// encoding, default data width and the {tlast, tkeep, tdata} entry layout.
package rx_frame_fifo_pkg;

  localparam int DATA_WIDTH_DEF = 64;

  typedef enum logic [1:0] {
    WR_IDLE   = 2'd0,
    WR_ACCEPT = 2'd1,
    WR_DROP   = 2'd2
  } wr_state_e;

  // Entry layout, low to high: tdata, tkeep, tlast.
  function automatic int keep_lsb(input int dw);
    return dw;
  endfunction

  function automatic int last_bit(input int dw);
    return dw + dw / 8;
  endfunction

  function automatic int entry_width(input int dw);
    return dw + dw / 8 + 1;
  endfunction

endpackage

// File: rtl/frame_fifo_ram.sv
// Simple dual-port storage for the rx frame FIFO: synchronous write,
// registered read. Contents are intentionally not reset.
module frame_fifo_ram #(
  parameter int WIDTH = 73,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Write port and registered read port; rdata holds until the next read.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
    if (re) begin
      rdata_q <= mem_q[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/rx_frame_fifo.sv
// Store-and-forward rx frame FIFO with overflow drop and FWFT output.
// Optional statistics counters are built when RX_FRAME_FIFO_STATS_EN is defined.
module rx_frame_fifo
  import rx_frame_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   s_tdata,
  input  logic [DATA_WIDTH/8-1:0] s_tkeep,
  input  logic                    s_tvalid,
  output logic                    s_tready,
  input  logic                    s_tlast,
  output logic [DATA_WIDTH-1:0]   m_tdata,
  output logic [DATA_WIDTH/8-1:0] m_tkeep,
  output logic                    m_tvalid,
  input  logic                    m_tready,
`ifdef RX_FRAME_FIFO_STATS_EN
  output logic [31:0]             frame_cnt,
  output logic [31:0]             drop_cnt,
`endif
  output logic                    m_tlast
);

  localparam int KW       = DATA_WIDTH / 8;
  localparam int EW       = entry_width(DATA_WIDTH);
  localparam int KEEP_LSB = keep_lsb(DATA_WIDTH);
  localparam int LAST_BIT = last_bit(DATA_WIDTH);
  localparam int AW       = $clog2(DEPTH);
  localparam int PW       = AW + 1;

  wr_state_e               state_q, state_d;
  logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]           commit_ptr_q, commit_ptr_d;
  logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]           fetch_ptr_q, fetch_ptr_d;
  logic                    mid_valid_q, mid_valid_d;
  logic                    m_tvalid_q, m_tvalid_d;
  logic                    m_tlast_q, m_tlast_d;
  logic [KW-1:0]           m_tkeep_q, m_tkeep_d;
  logic [DATA_WIDTH-1:0]   m_tdata_q, m_tdata_d;
  logic [EW-1:0]           ram_rdata_s;
  logic                    accept_s, full_s, ram_we_s, commit_s, drop_start_s;
  logic                    out_load_s, rd_issue_s, pop_s;

  assign s_tready     = ~rst;
  assign accept_s     = s_tvalid & s_tready;
  // rd_ptr only moves when a beat leaves m_*, so prefetched beats still occupy space.
  assign full_s       = (wr_ptr_q - rd_ptr_q) == PW'(DEPTH);
  assign ram_we_s     = accept_s & (state_q != WR_DROP) & ~full_s;
  assign commit_s     = ram_we_s & s_tlast;
  assign drop_start_s = accept_s & (state_q != WR_DROP) & full_s;

  assign pop_s      = m_tvalid_q & m_tready;
  assign out_load_s = mid_valid_q & (~m_tvalid_q | m_tready);
  assign rd_issue_s = (fetch_ptr_q != commit_ptr_q) & (~mid_valid_q | out_load_s);

  frame_fifo_ram #(.WIDTH(EW), .DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .we    (ram_we_s),
    .waddr (wr_ptr_q[AW-1:0]),
    .wdata ({s_tlast, s_tkeep, s_tdata}),
    .re    (rd_issue_s),
    .raddr (fetch_ptr_q[AW-1:0]),
    .rdata (ram_rdata_s)
  );

  // Next-state logic for the write FSM, pointers and output register.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    case (state_q)
      WR_IDLE, WR_ACCEPT: begin
        if (accept_s && !full_s) begin
          wr_ptr_d = wr_ptr_q + PW'(1);
          if (s_tlast) begin
            commit_ptr_d = wr_ptr_q + PW'(1);
            state_d      = WR_IDLE;
          end else begin
            state_d = WR_ACCEPT;
          end
        end else if (accept_s) begin
          wr_ptr_d = commit_ptr_q;
          state_d  = s_tlast ? WR_IDLE : WR_DROP;
        end else begin
          state_d = state_q;
        end
      end
      WR_DROP: begin
        if (accept_s && s_tlast) begin
          state_d = WR_IDLE;
        end else begin
          state_d = WR_DROP;
        end
      end
      default: state_d = WR_IDLE;
    endcase

    rd_ptr_d    = rd_ptr_q + (pop_s ? PW'(1) : PW'(0));
    fetch_ptr_d = fetch_ptr_q + (rd_issue_s ? PW'(1) : PW'(0));

    if (rd_issue_s) begin
      mid_valid_d = 1'b1;
    end else if (out_load_s) begin
      mid_valid_d = 1'b0;
    end else begin
      mid_valid_d = mid_valid_q;
    end

    if (out_load_s) begin
      m_tvalid_d = 1'b1;
      m_tlast_d  = ram_rdata_s[LAST_BIT];
      m_tkeep_d  = ram_rdata_s[KEEP_LSB +: KW];
      m_tdata_d  = ram_rdata_s[DATA_WIDTH-1:0];
    end else begin
      m_tvalid_d = pop_s ? 1'b0 : m_tvalid_q;
      m_tlast_d  = m_tlast_q;
      m_tkeep_d  = m_tkeep_q;
      m_tdata_d  = m_tdata_q;
    end
  end

  // State, pointer and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= WR_IDLE;
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
      fetch_ptr_q  <= '0;
      mid_valid_q  <= 1'b0;
      m_tvalid_q   <= 1'b0;
      m_tlast_q    <= 1'b0;
      m_tkeep_q    <= '0;
      m_tdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fetch_ptr_q  <= fetch_ptr_d;
      mid_valid_q  <= mid_valid_d;
      m_tvalid_q   <= m_tvalid_d;
      m_tlast_q    <= m_tlast_d;
      m_tkeep_q    <= m_tkeep_d;
      m_tdata_q    <= m_tdata_d;
    end
  end

  assign m_tvalid = m_tvalid_q;
  assign m_tlast  = m_tlast_q;
  assign m_tkeep  = m_tkeep_q;
  assign m_tdata  = m_tdata_q;

`ifdef RX_FRAME_FIFO_STATS_EN
  logic [31:0] frame_cnt_q, frame_cnt_d;
  logic [31:0] drop_cnt_q, drop_cnt_d;

  // Saturating committed/dropped frame counters.
  always_comb begin
    if (commit_s && (frame_cnt_q != 32'hFFFF_FFFF)) begin
      frame_cnt_d = frame_cnt_q + 32'd1;
    end else begin
      frame_cnt_d = frame_cnt_q;
    end
    if (drop_start_s && (drop_cnt_q != 32'hFFFF_FFFF)) begin
      drop_cnt_d = drop_cnt_q + 32'd1;
    end else begin
      drop_cnt_d = drop_cnt_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_q <= 32'd0;
      drop_cnt_q  <= 32'd0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign drop_cnt  = drop_cnt_q;
`else
  logic unused_stats_s;
  assign unused_stats_s = commit_s ^ drop_start_s;
`endif

endmodule

// File: tb/tb_rx_frame_fifo.sv
// Directed, self-checking bench for rx_frame_fifo (DATA_WIDTH=64, DEPTH=16).
// Counter checks are built when RX_FRAME_FIFO_STATS_EN is defined.
module tb_rx_frame_fifo;

  logic        clk;
  logic        rst;
  logic [63:0] s_tdata;
  logic [7:0]  s_tkeep;
  logic        s_tvalid;
  logic        s_tready;
  logic        s_tlast;
  logic [63:0] m_tdata;
  logic [7:0]  m_tkeep;
  logic        m_tvalid;
  logic        m_tready;
  logic        m_tlast;
`ifdef RX_FRAME_FIFO_STATS_EN
  logic [31:0] frame_cnt;
  logic [31:0] drop_cnt;
`endif

  rx_frame_fifo #(.DATA_WIDTH(64), .DEPTH(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .s_tdata  (s_tdata),
    .s_tkeep  (s_tkeep),
    .s_tvalid (s_tvalid),
    .s_tready (s_tready),
    .s_tlast  (s_tlast),
    .m_tdata  (m_tdata),
    .m_tkeep  (m_tkeep),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready),
`ifdef RX_FRAME_FIFO_STATS_EN
    .frame_cnt(frame_cnt),
    .drop_cnt (drop_cnt),
`endif
    .m_tlast  (m_tlast)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        vld;
    logic        last;
    logic [7:0]  keep;
    logic [63:0] data;
    logic        e_vld;
    logic        e_last;
    logic [7:0]  e_keep;
    logic [63:0] e_data;
  } vec_t;

  int n_cmp = 0;
  int n_err = 0;
  logic [72:0] got_q[$];
  logic [72:0] exp_q[$];
  logic        stab_en   = 1'b0;
  logic        toggle_en = 1'b0;
  logic        prev_stall = 1'b0;
  logic [73:0] prev_out;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] mkd(input int f, input int b);
    return {8'(f), 8'(b), 16'(f * 7 + b), 32'hC0DE_0000 | 32'(f * 256 + b)};
  endfunction

  // Inputs are already set; sample before the coming posedge, then move to the next negedge.
  task automatic tick();
    logic [73:0] cur;
    if (toggle_en) m_tready = ~m_tready;
    #2;
    cur = {m_tvalid, m_tlast, m_tkeep, m_tdata};
    if (stab_en && prev_stall) chk("stable_while_stalled", 128'(cur), 128'(prev_out));
    prev_stall = m_tvalid && !m_tready;
    prev_out   = cur;
    if (m_tvalid && m_tready) got_q.push_back({m_tlast, m_tkeep, m_tdata});
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send_frame(input int f, input int n, input logic [7:0] lk, input logic expect_out);
    for (int b = 0; b < n; b++) begin
      s_tvalid = 1'b1;
      s_tdata  = mkd(f, b);
      s_tkeep  = (b == n - 1) ? lk : 8'hFF;
      s_tlast  = (b == n - 1);
      if (expect_out) exp_q.push_back({s_tlast, s_tkeep, s_tdata});
      tick();
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic check_stream(input string name);
    int n;
    chk({name, "_count"}, 128'(got_q.size()), 128'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk(name, 128'(got_q[i]), 128'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    s_tvalid   = 1'b0;
    s_tlast    = 1'b0;
    stab_en    = 1'b0;
    toggle_en  = 1'b0;
    prev_stall = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic chk_counters(input string name, input int frames, input int drops);
`ifdef RX_FRAME_FIFO_STATS_EN
    chk({name, "_frame_cnt"}, 128'(frame_cnt), 128'(frames));
    chk({name, "_drop_cnt"}, 128'(drop_cnt), 128'(drops));
`else
    if (frames < 0 || drops < 0) $display("note %s: negative counter expectation", name);
`endif
  endtask

  vec_t tbl[9];

  initial begin
    rst = 1'b1; s_tdata = 64'd0; s_tkeep = 8'd0; s_tvalid = 1'b0; s_tlast = 1'b0;
    m_tready = 1'b1;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("reset_outputs", 128'({s_tready, m_tvalid, m_tlast, m_tkeep, m_tdata}), 128'(0));
    rst = 1'b0;
    chk_counters("reset", 0, 0);

    // 3-beat frame: latency and content, cycle by cycle
    tbl[0] = '{1'b1, 1'b0, 8'hFF, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b0, 8'h00, 64'd0};
    tbl[1] = '{1'b1, 1'b0, 8'hFF, 64'hFEDC_BA98_7654_3210, 1'b0, 1'b0, 8'h00, 64'd0};
    tbl[2] = '{1'b1, 1'b1, 8'h0F, 64'h0000_0000_DEAD_BEEF, 1'b0, 1'b0, 8'h00, 64'd0};
    tbl[3] = '{1'b0, 1'b0, 8'h00, 64'd0, 1'b0, 1'b0, 8'h00, 64'd0};
    tbl[4] = '{1'b0, 1'b0, 8'h00, 64'd0, 1'b0, 1'b0, 8'h00, 64'd0};
    tbl[5] = '{1'b0, 1'b0, 8'h00, 64'd0, 1'b1, 1'b0, 8'hFF, 64'h0123_4567_89AB_CDEF};
    tbl[6] = '{1'b0, 1'b0, 8'h00, 64'd0, 1'b1, 1'b0, 8'hFF, 64'hFEDC_BA98_7654_3210};
    tbl[7] = '{1'b0, 1'b0, 8'h00, 64'd0, 1'b1, 1'b1, 8'h0F, 64'h0000_0000_DEAD_BEEF};
    tbl[8] = '{1'b0, 1'b0, 8'h00, 64'd0, 1'b0, 1'b0, 8'h00, 64'd0};
    for (int i = 0; i < 9; i++) begin
      if (tbl[i].e_vld)
        chk($sformatf("vec%0d_beat", i), 128'({m_tvalid, m_tlast, m_tkeep, m_tdata}),
            128'({tbl[i].e_vld, tbl[i].e_last, tbl[i].e_keep, tbl[i].e_data}));
      else
        chk($sformatf("vec%0d_valid", i), 128'(m_tvalid), 128'(0));
      s_tvalid = tbl[i].vld;
      s_tlast  = tbl[i].last;
      s_tkeep  = tbl[i].keep;
      s_tdata  = tbl[i].data;
      @(negedge clk);
    end
    chk_counters("three_beat", 1, 0);

    // Oversized frame is dropped whole; next frame intact
    do_reset();
    m_tready = 1'b1;
    send_frame(1, 20, 8'hFF, 1'b0);
    idle(6);
    send_frame(2, 4, 8'h03, 1'b1);
    idle(8);
    check_stream("oversize_then_ok");
    chk_counters("oversize", 1, 1);

    // Backpressure fills the FIFO; third frame dropped, then drain 16 beats
    do_reset();
    m_tready = 1'b0;
    stab_en  = 1'b1;
    send_frame(3, 8, 8'hFF, 1'b1);
    send_frame(4, 8, 8'h7F, 1'b1);
    send_frame(5, 2, 8'h01, 1'b0);
    idle(3);
    chk("held_head", 128'({m_tvalid, m_tdata}), 128'({1'b1, mkd(3, 0)}));
    m_tready = 1'b1;
    idle(22);
    check_stream("full_drain");
    chk_counters("full", 2, 1);

    // Toggling m_tready: no loss, no duplication, stable while stalled
    do_reset();
    stab_en   = 1'b1;
    toggle_en = 1'b1;
    send_frame(6, 6, 8'h3F, 1'b1);
    idle(24);
    toggle_en = 1'b0;
    m_tready  = 1'b1;
    check_stream("toggle_ready");

    // Reset mid-frame while a committed beat is held at the output
    do_reset();
    m_tready = 1'b0;
    send_frame(7, 1, 8'hFF, 1'b0);
    idle(4);
    chk("pre_reset_valid", 128'(m_tvalid), 128'(1));
    s_tvalid = 1'b1; s_tdata = mkd(8, 0); s_tkeep = 8'hFF; s_tlast = 1'b0;
    tick();
    s_tdata = mkd(8, 1);
    rst = 1'b1;
    tick();
    chk("reset_mid_frame", 128'({s_tready, m_tvalid}), 128'(0));
    rst = 1'b0;
    s_tvalid = 1'b0;
    got_q.delete();
    m_tready = 1'b1;
    send_frame(9, 2, 8'h1F, 1'b1);
    idle(8);
    check_stream("after_reset");
    chk_counters("after_reset", 1, 0);

    // 100 back-to-back 1-beat frames: pointer wrap, no drops
    do_reset();
    m_tready = 1'b1;
    for (int f = 0; f < 100; f++) send_frame(f + 16, 1, 8'(f), 1'b1);
    idle(8);
    check_stream("single_beat_stream");
    chk_counters("single_beat", 100, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
